kamacore_stage_lsu: RTL and testbench
=====================================

// Module: kamacore_stage_lsu
// PURPOSE
//  Parametrised load/store memory stage between EX and WB. Replaces the fixed-latency read-only stage:
//  real loads/stores with byte/half/word(/double) sizes, sign/zero extension, byte enables, valid/ready
//  handshakes both sides, and a req/gnt/rvalid memory port tolerating arbitrary grant and response latency.
// PARAMETERS
//  XLEN      32  datapath width; 32 or 64 only
//  ADDR_W    32  memory address width
//  CNT_W     16  width of the saturating stall counter
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active-low
//  in_valid       in   1        EX->MEM op valid
//  in_ready       out  1        stage can accept op this cycle
//  in_alu_result  in   XLEN     effective address / ALU result
//  in_store_data  in   XLEN     store source (rs2)
//  in_instruction in   32       instruction word, passed through
//  in_mem_read    in   1        op is a load
//  in_mem_write   in   1        op is a store (read&write both set: treated as plain ALU op)
//  in_size        in   2        0=B 1=H 2=W 3=D (D legal only if XLEN==64)
//  in_unsigned    in   1        zero-extend load result
//  out_valid      out  1        MEM->WB result valid
//  out_ready      in   1        WB accepts result
//  out_alu_result out  XLEN     registered in_alu_result
//  out_load_data  out  XLEN     extended load data (0 for non-loads)
//  out_instruction out 32       registered instruction
//  mem_req/mem_gnt out/in 1     request held until gnt
//  mem_we         out  1        write request
//  mem_addr       out  ADDR_W   aligned address, low log2(XLEN/8) bits zero
//  mem_be         out  XLEN/8   byte enables
//  mem_wdata      out  XLEN     lane-replicated store data
//  mem_rvalid     in   1        load response; earliest cycle after gnt
//  mem_rdata      in   XLEN     load response data
//  stall_cnt      out  CNT_W    cycles with in_valid&~in_ready, saturating
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (in_ready=0 during reset cycle, 1 first cycle after).
//  FSM IDLE->(accept ALU op)->DONE; IDLE->(accept mem op)->REQ; REQ: mem_req=1, on gnt: store->DONE,
//   load->WAIT; WAIT: on rvalid capture extended data ->DONE; DONE: out_valid=1, on out_ready -> IDLE,
//   or -> DONE/REQ directly if a new op is accepted the same cycle.
//  in_ready = IDLE | (DONE & out_ready). Accept = in_valid & in_ready. ALU op latency 1 cycle.
//  Load latency = 1 + gnt wait + rvalid wait; store = 1 + gnt wait. One op in flight max.
//  mem_* signals stable while mem_req=1 and gnt=0. rvalid outside WAIT is ignored.
//  Lanes: off=addr[log2(XLEN/8)-1:0]; be = ((1<<2^size)-1)<<off; rdata shifted right by off*8 then
//   sign/zero extended from 2^size bytes. Size D with XLEN==32 behaves as W.
//  out_* hold stable while out_valid & ~out_ready. stall_cnt saturates at all-ones, never wraps.
//  Reset mid-op: mem_req drops same cycle; pending response discarded; no partial output.
// CONFIGURATION
//  KAMACORE_LSU_MISALIGN_TRAP_EN defined: extra port out_misaligned (out,1). Access with
//   off not a multiple of 2^size skips memory, goes to DONE next cycle with out_misaligned=1,
//   out_load_data=0. Not defined: low size bits of off forced to zero (access silently aligned).
// STRUCTURE
//  kamacore_pkg: CPU_WIDTH, mem_size_e (MEM_B/H/W/D), lsu_state_e (IDLE/REQ/WAIT/DONE).
//  Sub-module kamacore_lsu_align: combinational be/wdata steering and load extract/extend.
// TESTING
//  LB addr 0x103, rdata 0x80FF_0000 -> out_load_data 0xFFFF_FF80; LBU -> 0x0000_0080.
//  SH addr 0x102 data 0x1234 -> mem_be 4'b1100, mem_wdata 0x1234_1234, mem_we=1.
//  gnt delayed 3 cycles, rvalid 2 after gnt -> out_valid 6 cycles after accept; mem_* stable.
//  ALU op stream with out_ready=1 -> one result per cycle; out_ready=0 4 cycles -> stall_cnt +=4.
//  rst=0 while in WAIT, late rvalid -> no out_valid, mem_req=0, outputs 0.
//  (TRAP_EN) LW addr 0x2 -> no mem_req, out_misaligned=1 next cycle; without macro -> mem_addr 0x0.

Source files
------------

// File: rtl/kamacore_pkg.sv
// Shared types for the kamacore load/store stage.
// Sizes, FSM states and the default datapath width.
package kamacore_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    function automatic logic [1:0] lsu_eff_size(input logic [1:0] sz,
                                                input int xlen);
        if (xlen == 32 && sz == MEM_D)
            return MEM_W;
        return sz;
    endfunction

endpackage

// File: rtl/kamacore_lsu_align.sv
// Byte-lane steering for stores and lane extract/extend for loads.
// Purely combinational; the store side also reports misalignment.
module kamacore_lsu_align
    import kamacore_pkg::*;
#(
    parameter int XLEN = CPU_WIDTH
) (
    input  logic [$clog2(XLEN/8)-1:0] st_off_i,
    input  logic [1:0]                st_size_i,
    input  logic [XLEN-1:0]           st_data_i,
    output logic [$clog2(XLEN/8)-1:0] st_off_o,
    output logic [XLEN/8-1:0]         st_be_o,
    output logic [XLEN-1:0]           st_wdata_o,
    output logic                      st_misaligned_o,
    input  logic [$clog2(XLEN/8)-1:0] ld_off_i,
    input  logic [1:0]                ld_size_i,
    input  logic                      ld_unsigned_i,
    input  logic [XLEN-1:0]           ld_rdata_i,
    output logic [XLEN-1:0]           ld_data_o
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    logic [1:0]       st_sz;
    logic [1:0]       ld_sz;
    logic [OFF_W-1:0] st_mask;
    logic [XLEN-1:0]  shifted;

    always_comb begin
        st_sz           = lsu_eff_size(st_size_i, XLEN);
        st_mask         = OFF_W'((32'd1 << st_sz) - 32'd1);
        st_off_o        = st_off_i & ~st_mask;
        st_misaligned_o = |(st_off_i & st_mask);
        st_be_o = NB'(((32'd1 << (32'd1 << st_sz)) - 32'd1) << st_off_o);
        unique case (st_sz)
            2'd0:    st_wdata_o = {NB{st_data_i[7:0]}};
            2'd1:    st_wdata_o = {(NB/2){st_data_i[15:0]}};
            2'd2:    st_wdata_o = {(NB/4){st_data_i[31:0]}};
            default: st_wdata_o = st_data_i;
        endcase
    end

    always_comb begin
        ld_sz   = lsu_eff_size(ld_size_i, XLEN);
        shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        unique case (ld_sz)
            2'd0: ld_data_o = ld_unsigned_i ? XLEN'(shifted[7:0])
                                            : XLEN'($signed(shifted[7:0]));
            2'd1: ld_data_o = ld_unsigned_i ? XLEN'(shifted[15:0])
                                            : XLEN'($signed(shifted[15:0]));
            2'd2: ld_data_o = ld_unsigned_i ? XLEN'(shifted[31:0])
                                            : XLEN'($signed(shifted[31:0]));
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/kamacore_stage_lsu.sv
// Load/store memory stage between EX and WB, one op in flight.
// Optional KAMACORE_LSU_MISALIGN_TRAP_EN adds out_misaligned trapping.
module kamacore_stage_lsu
    import kamacore_pkg::*;
#(
    parameter int XLEN   = CPU_WIDTH,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_alu_result,
    input  logic [XLEN-1:0]     in_store_data,
    input  logic [31:0]         in_instruction,
    input  logic                in_mem_read,
    input  logic                in_mem_write,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_alu_result,
    output logic [XLEN-1:0]     out_load_data,
    output logic [31:0]         out_instruction,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [CNT_W-1:0]    stall_cnt
`ifdef KAMACORE_LSU_MISALIGN_TRAP_EN
    ,
    output logic                out_misaligned
`endif
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e       state_q;
    logic             is_load_q;
    logic [OFF_W-1:0] ld_off_q;
    logic [1:0]       ld_size_q;
    logic             ld_uns_q;
    logic             misaligned_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic              accept;
    logic              is_mem;
    logic              is_load;
    logic              is_store;
    logic              trap;
    logic [ADDR_W-1:0] addr_full;
    logic [OFF_W-1:0]  st_off;
    logic [NB-1:0]     st_be;
    logic [XLEN-1:0]   st_wdata;
    logic              st_mis;
    logic [XLEN-1:0]   ld_data;

    if (ADDR_W <= XLEN) begin : g_addr_trunc
        assign addr_full = in_alu_result[ADDR_W-1:0];
    end else begin : g_addr_ext
        assign addr_full = {{(ADDR_W-XLEN){1'b0}}, in_alu_result};
    end

    kamacore_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .st_off_i        (in_alu_result[OFF_W-1:0]),
        .st_size_i       (in_size),
        .st_data_i       (in_store_data),
        .st_off_o        (st_off),
        .st_be_o         (st_be),
        .st_wdata_o      (st_wdata),
        .st_misaligned_o (st_mis),
        .ld_off_i        (ld_off_q),
        .ld_size_i       (ld_size_q),
        .ld_unsigned_i   (ld_uns_q),
        .ld_rdata_i      (mem_rdata),
        .ld_data_o       (ld_data)
    );

    // read&write together is deliberately an ALU op, not a memory op
    assign is_mem   = in_mem_read ^ in_mem_write;
    assign is_load  = in_mem_read & ~in_mem_write;
    assign is_store = in_mem_write & ~in_mem_read;

`ifdef KAMACORE_LSU_MISALIGN_TRAP_EN
    assign trap           = is_mem & st_mis;
    assign out_misaligned = misaligned_q;
`else
    assign trap = 1'b0;
`endif

    assign in_ready  = rst & ((state_q == IDLE) |
                              ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign mem_req   = rst & (state_q == REQ);
    assign out_valid = rst & (state_q == DONE);
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            is_load_q       <= 1'b0;
            ld_off_q        <= '0;
            ld_size_q       <= '0;
            ld_uns_q        <= 1'b0;
            misaligned_q    <= 1'b0;
            stall_cnt_q     <= '0;
            out_alu_result  <= '0;
            out_load_data   <= '0;
            out_instruction <= '0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_be          <= '0;
            mem_wdata       <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            unique case (state_q)
                REQ: begin
                    if (mem_gnt)
                        state_q <= is_load_q ? WAIT : DONE;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q       <= DONE;
                        out_load_data <= ld_data;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: ;
            endcase
            if (accept) begin
                state_q         <= (is_mem && !trap) ? REQ : DONE;
                out_alu_result  <= in_alu_result;
                out_instruction <= in_instruction;
                out_load_data   <= '0;
                misaligned_q    <= trap;
                is_load_q       <= is_load;
                ld_off_q        <= st_off;
                ld_size_q       <= in_size;
                ld_uns_q        <= in_unsigned;
                mem_we          <= is_store;
                mem_addr        <= addr_full & ~ADDR_W'(NB - 1);
                mem_be          <= st_be;
                mem_wdata       <= is_store ? st_wdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_kamacore_stage_lsu.sv
// Directed self-checking bench for kamacore_stage_lsu (XLEN=32).
// Define KAMACORE_LSU_MISALIGN_TRAP_EN to exercise the trap build.
module tb_kamacore_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [31:0] in_instruction;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_result;
    logic [31:0] out_load_data;
    logic [31:0] out_instruction;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [15:0] stall_cnt;
`ifdef KAMACORE_LSU_MISALIGN_TRAP_EN
    logic        out_misaligned;
`endif

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    kamacore_stage_lsu #(
        .XLEN(32),
        .ADDR_W(32),
        .CNT_W(16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_alu_result   (in_alu_result),
        .in_store_data   (in_store_data),
        .in_instruction  (in_instruction),
        .in_mem_read     (in_mem_read),
        .in_mem_write    (in_mem_write),
        .in_size         (in_size),
        .in_unsigned     (in_unsigned),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_alu_result  (out_alu_result),
        .out_load_data   (out_load_data),
        .out_instruction (out_instruction),
        .mem_req         (mem_req),
        .mem_gnt         (mem_gnt),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .stall_cnt       (stall_cnt)
`ifdef KAMACORE_LSU_MISALIGN_TRAP_EN
        ,
        .out_misaligned  (out_misaligned)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk({tag, "_retired"}, out_valid, 1'b0);
    endtask

    task automatic load_op(input string tag, input logic [31:0] addr,
                           input logic [1:0] sz, input logic uns,
                           input logic [31:0] rdata,
                           input logic [31:0] exp_addr,
                           input logic [3:0] exp_be,
                           input logic [31:0] exp_data,
                           input int gw, input int rw, output int l);
        in_valid = 1'b1;
        in_mem_read = 1'b1;
        in_mem_write = 1'b0;
        in_alu_result = addr;
        in_size = sz;
        in_unsigned = uns;
        in_store_data = 32'h5555_5555;
        in_instruction = {16'hC0DE, addr[15:0]};
        #1 chk({tag, "_in_ready"}, in_ready, 1'b1);
        cyc();
        l = 1;
        in_valid = 1'b0;
        in_alu_result = 32'hFFFF_FFFF;
        in_size = 2'd0;
        for (int i = 0; i < gw; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
            chk({tag, "_req_wait"}, mem_req, 1'b1);
            chk({tag, "_addr_wait"}, mem_addr, exp_addr);
            cyc();
            l++;
        end
        mem_rvalid = 1'b0;
        mem_gnt = 1'b1;
        chk({tag, "_req"}, mem_req, 1'b1);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_be"}, mem_be, exp_be);
        cyc();
        l++;
        mem_gnt = 1'b0;
        chk({tag, "_req_after_gnt"}, mem_req, 1'b0);
        for (int i = 0; i < rw - 1; i++) begin
            chk({tag, "_no_valid_yet"}, out_valid, 1'b0);
            cyc();
            l++;
        end
        mem_rvalid = 1'b1;
        mem_rdata = rdata;
        cyc();
        l++;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_load_data, exp_data);
        chk({tag, "_alu"}, out_alu_result, addr);
        chk({tag, "_instr"}, out_instruction, {16'hC0DE, addr[15:0]});
        retire(tag);
    endtask

    task automatic store_op(input string tag, input logic [31:0] addr,
                            input logic [1:0] sz, input logic [31:0] data,
                            input logic [31:0] exp_addr,
                            input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input int gw);
        in_valid = 1'b1;
        in_mem_read = 1'b0;
        in_mem_write = 1'b1;
        in_alu_result = addr;
        in_size = sz;
        in_unsigned = 1'b0;
        in_store_data = data;
        in_instruction = {16'h5707, addr[15:0]};
        #1 chk({tag, "_in_ready"}, in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        in_store_data = 32'h0;
        for (int i = 0; i < gw; i++) begin
            chk({tag, "_wdata_wait"}, mem_wdata, exp_wdata);
            chk({tag, "_be_wait"}, mem_be, exp_be);
            cyc();
        end
        mem_gnt = 1'b1;
        chk({tag, "_req"}, mem_req, 1'b1);
        chk({tag, "_we"}, mem_we, 1'b1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_be"}, mem_be, exp_be);
        chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        cyc();
        mem_gnt = 1'b0;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_ldata_zero"}, out_load_data, 32'h0);
        chk({tag, "_req_done"}, mem_req, 1'b0);
        retire(tag);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_alu_result = '0;
        in_store_data = '0;
        in_instruction = '0;
        in_mem_read = 1'b0;
        in_mem_write = 1'b0;
        in_size = 2'd0;
        in_unsigned = 1'b0;
        out_ready = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;

        cyc();
        cyc();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_ldata", out_load_data, 32'h0);
        chk("rst_stall", stall_cnt, 16'h0);
        rst = 1'b1;
        cyc();
        chk("post_rst_in_ready", in_ready, 1'b1);

        load_op("lb", 32'h103, 2'd0, 1'b0, 32'h80FF_0000, 32'h100, 4'b1000,
                32'hFFFF_FF80, 2, 2, lat);
        chk("lb_latency", lat, 6);
        load_op("lbu", 32'h103, 2'd0, 1'b1, 32'h80FF_0000, 32'h100, 4'b1000,
                32'h0000_0080, 0, 1, lat);
        chk("lbu_latency", lat, 3);
        load_op("lh", 32'h102, 2'd1, 1'b0, 32'h8001_7777, 32'h100, 4'b1100,
                32'hFFFF_8001, 1, 1, lat);
        load_op("lhu", 32'h100, 2'd1, 1'b1, 32'h1234_F00D, 32'h100, 4'b0011,
                32'h0000_F00D, 0, 3, lat);
        load_op("ld_as_w", 32'h104, 2'd3, 1'b0, 32'hCAFE_BABE, 32'h104,
                4'b1111, 32'hCAFE_BABE, 0, 1, lat);

        store_op("sh", 32'h102, 2'd1, 32'h0000_1234, 32'h100, 4'b1100,
                 32'h1234_1234, 0);
        store_op("sb", 32'h101, 2'd0, 32'hFFFF_FFAB, 32'h100, 4'b0010,
                 32'hABAB_ABAB, 3);
        store_op("sw", 32'h200, 2'd2, 32'hDEAD_BEEF, 32'h200, 4'b1111,
                 32'hDEAD_BEEF, 1);

`ifdef KAMACORE_LSU_MISALIGN_TRAP_EN
        in_valid = 1'b1;
        in_mem_read = 1'b1;
        in_mem_write = 1'b0;
        in_alu_result = 32'h2;
        in_size = 2'd2;
        in_unsigned = 1'b0;
        cyc();
        in_valid = 1'b0;
        chk("mis_no_req", mem_req, 1'b0);
        chk("mis_valid", out_valid, 1'b1);
        chk("mis_flag", out_misaligned, 1'b1);
        chk("mis_ldata", out_load_data, 32'h0);
        retire("mis");
`else
        load_op("lw_mis", 32'h2, 2'd2, 1'b0, 32'h1122_3344, 32'h0, 4'b1111,
                32'h1122_3344, 0, 1, lat);
`endif

        chk("stall_before", stall_cnt, 16'h0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_alu_result = 32'h1000 + i;
            in_instruction = 32'(i);
            in_mem_read = (i == 4);
            in_mem_write = (i == 4);
            cyc();
            chk("alu_valid", out_valid, 1'b1);
            chk("alu_result", out_alu_result, 32'h1000 + i);
            chk("alu_ldata", out_load_data, 32'h0);
            chk("alu_no_req", mem_req, 1'b0);
        end
        in_mem_read = 1'b0;
        in_mem_write = 1'b0;
        in_alu_result = 32'h2000;
        out_ready = 1'b0;
        #1 chk("stall_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_alu", out_alu_result, 32'h1004);
        end
        chk("stall_cnt4", stall_cnt, 16'd4);
        out_ready = 1'b1;
        cyc();
        chk("after_stall_alu", out_alu_result, 32'h2000);
        chk("after_stall_cnt", stall_cnt, 16'd4);
        in_valid = 1'b0;
        cyc();
        chk("after_stall_idle", out_valid, 1'b0);
        out_ready = 1'b0;

        in_valid = 1'b1;
        in_mem_read = 1'b1;
        in_alu_result = 32'h40;
        in_size = 2'd2;
        cyc();
        in_valid = 1'b0;
        chk("rreq_req", mem_req, 1'b1);
        rst = 1'b0;
        #1 chk("rreq_req_drop", mem_req, 1'b0);
        chk("rreq_in_ready", in_ready, 1'b0);
        cyc();
        rst = 1'b1;
        chk("rreq_mem_addr", mem_addr, 32'h0);
        chk("rreq_stall_clr", stall_cnt, 16'h0);
        #1 chk("rreq_ready", in_ready, 1'b1);

        in_valid = 1'b1;
        in_alu_result = 32'h44;
        cyc();
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        cyc();
        mem_rvalid = 1'b0;
        chk("rwait_no_valid", out_valid, 1'b0);
        chk("rwait_ldata", out_load_data, 32'h0);
        chk("rwait_req", mem_req, 1'b0);
        chk("rwait_alu", out_alu_result, 32'h0);
        cyc();
        chk("rwait_still_idle", out_valid, 1'b0);
        chk("rwait_ready", in_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
